up_dn_counter_gen: RTL and testbench

Parametrised successor to the 5-bit up/down counter. Width and step size are configurable, and the lower and upper bounds are programmable at run time. Overflow and underflow can either saturate or wrap, selected by a mode input, and the block raises registered overflow/underflow event pulses alongside the High/Low bound flags. It is used as a general event/position counter in datapath and control blocks.

---
 rtl/up_dn_counter_gen_if.sv | 32 +++
 rtl/up_dn_counter_gen.sv | 109 ++++++++++
 tb/tb_up_dn_counter_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/up_dn_counter_gen_if.sv
// Control, bound and status signals of the programmable up/down counter.
// The master drives count/load/bound controls; the slave (counter) returns state and flags.
interface up_dn_counter_gen_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              EN;
  logic              Load;
  logic [WIDTH-1:0]  IN;
  logic              Up;
  logic              Down;
  logic [STEP_W-1:0] Step;
  logic [WIDTH-1:0]  Min;
  logic [WIDTH-1:0]  Max;
  logic              Wrap;
  logic [WIDTH-1:0]  Counter;
  logic              High;
  logic              Low;
  logic              Ovf;
  logic              Unf;
  logic              Cfg_Err;

  modport master (
    output EN, Load, IN, Up, Down, Step, Min, Max, Wrap,
    input  Counter, High, Low, Ovf, Unf, Cfg_Err
  );

  modport slave (
    input  EN, Load, IN, Up, Down, Step, Min, Max, Wrap,
    output Counter, High, Low, Ovf, Unf, Cfg_Err
  );
endinterface

// File: rtl/up_dn_counter_gen.sv
// Up/down counter with run-time bounds, saturate/wrap mode and registered ovf/unf pulses.
// Latency: one cycle from inputs to Counter/Ovf/Unf; no backpressure, a command is taken every cycle.
module up_dn_counter_gen #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  up_dn_counter_gen_if.slave   bus
);

  // Extended width holds any sum/difference of counter and step with one spare bit.
  localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [WIDTH-1:0] cnt_q;
  logic             ovf_q;
  logic             unf_q;

  logic [WIDTH-1:0] cnt_d;
  logic             ovf_d;
  logic             unf_d;

  logic [EW-1:0]    cnt_x;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    min_x;
  logic [EW-1:0]    max_x;
  logic [EW-1:0]    sum_x;
  logic [EW-1:0]    diff_x;

  logic             cfg_err;
  logic             step_nz;
  logic             do_dn;
  logic             do_up;
  logic             sum_ovf;
  logic             diff_unf;
  logic [WIDTH-1:0] load_val;

  assign cfg_err = (bus.Min > bus.Max);
  assign step_nz = (bus.Step != '0);

  assign cnt_x  = EW'(cnt_q);
  assign step_x = EW'(bus.Step);
  assign min_x  = EW'(bus.Min);
  assign max_x  = EW'(bus.Max);
  assign sum_x  = cnt_x + step_x;
  assign diff_x = cnt_x - step_x;

  // A counter already outside the bounds still compares correctly here, so
  // a stale value above Max overflows on any Up and below Min underflows on any Down.
  assign sum_ovf  = (sum_x > max_x);
  assign diff_unf = (step_x > cnt_x) || (diff_x < min_x);

  assign do_dn = bus.EN & bus.Down & step_nz;
  assign do_up = bus.EN & bus.Up & ~bus.Down & step_nz;

  always_comb begin
    load_val = bus.IN;
    if (bus.IN < bus.Min) begin
      load_val = bus.Min;
    end else if (bus.IN > bus.Max) begin
      load_val = bus.Max;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!cfg_err) begin
      if (bus.Load) begin
        cnt_d = load_val;
      end else if (do_dn) begin
        if (diff_unf) begin
          cnt_d = bus.Wrap ? bus.Max : bus.Min;
          unf_d = 1'b1;
        end else begin
          cnt_d = diff_x[WIDTH-1:0];
        end
      end else if (do_up) begin
        if (sum_ovf) begin
          cnt_d = bus.Wrap ? bus.Min : bus.Max;
          ovf_d = 1'b1;
        end else begin
          cnt_d = sum_x[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= bus.Min;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.Counter = cnt_q;
  assign bus.Ovf     = ovf_q;
  assign bus.Unf     = unf_q;
  assign bus.High    = (cnt_q >= bus.Max);
  assign bus.Low     = (cnt_q <= bus.Min);
  assign bus.Cfg_Err = cfg_err;

endmodule

// File: tb/tb_up_dn_counter_gen.sv
// Scoreboard bench: driver computes expected post-edge state from an integer model,
// monitor pops one record per clock and compares against the counter outputs.
module tb_up_dn_counter_gen;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int VMAX   = (1 << WIDTH) - 1;

  typedef struct {
    int cnt;
    int ovf;
    int unf;
    int high;
    int low;
    int cfg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  up_dn_counter_gen_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  up_dn_counter_gen #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   m_cnt    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: next counter value from the behavioural rules, using plain ints.
  task automatic drive(input bit r, input bit e, input bit ld, input int iv,
                       input bit u, input bit d, input int st,
                       input int mn, input int mx, input bit w);
    exp_t x;
    int   n;
    int   o;
    int   un;
    @(negedge clk);
    rst      = r;
    bus.EN   = e;
    bus.Load = ld;
    bus.IN   = iv[WIDTH-1:0];
    bus.Up   = u;
    bus.Down = d;
    bus.Step = st[STEP_W-1:0];
    bus.Min  = mn[WIDTH-1:0];
    bus.Max  = mx[WIDTH-1:0];
    bus.Wrap = w;
    n  = m_cnt;
    o  = 0;
    un = 0;
    if (r) begin
      n = mn;
    end else if (mn > mx) begin
      n = m_cnt;
    end else if (ld) begin
      n = (iv < mn) ? mn : ((iv > mx) ? mx : iv);
    end else if (e && st != 0 && d) begin
      if (m_cnt - st < mn) begin
        n  = w ? mx : mn;
        un = 1;
      end else begin
        n = m_cnt - st;
      end
    end else if (e && st != 0 && u) begin
      if (m_cnt + st > mx) begin
        n = w ? mn : mx;
        o = 1;
      end else begin
        n = m_cnt + st;
      end
    end
    m_cnt  = n;
    x.cnt  = n;
    x.ovf  = o;
    x.unf  = un;
    x.high = (n >= mx) ? 1 : 0;
    x.low  = (n <= mn) ? 1 : 0;
    x.cfg  = (mn > mx) ? 1 : 0;
    exp_q.push_back(x);
  endtask

  // Monitor: inputs stay stable until the next negedge, so Cfg_Err/High/Low
  // seen just after the edge belong to the same record.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("counter", int'(bus.Counter), x.cnt);
        check("ovf",     int'(bus.Ovf),     x.ovf);
        check("unf",     int'(bus.Unf),     x.unf);
        check("high",    int'(bus.High),    x.high);
        check("low",     int'(bus.Low),     x.low);
        check("cfg_err", int'(bus.Cfg_Err), x.cfg);
      end
    end
  end

  initial begin
    int mn;
    int mx;
    int waited;
    bus.EN   = 1'b0;
    bus.Load = 1'b0;
    bus.IN   = '0;
    bus.Up   = 1'b0;
    bus.Down = 1'b0;
    bus.Step = '0;
    bus.Min  = '0;
    bus.Max  = '0;
    bus.Wrap = 1'b0;

    // reset to Min
    drive(1, 0, 0, 0,   0, 0, 0, 5, 200, 0);
    drive(0, 0, 0, 0,   0, 0, 0, 5, 200, 0);
    // clamped loads, independent of EN
    drive(0, 0, 1, 250, 0, 0, 0, 5, 200, 0);
    drive(0, 0, 1, 2,   0, 0, 0, 5, 200, 0);
    // Up+Down decrements, then Up twice
    drive(0, 0, 1, 100, 0, 0, 0, 5, 200, 0);
    drive(0, 1, 0, 0,   1, 1, 3, 5, 200, 0);
    drive(0, 1, 0, 0,   1, 0, 3, 5, 200, 0);
    drive(0, 1, 0, 0,   1, 0, 3, 5, 200, 0);
    // saturate at Max, repeated Ovf, Step=0 hold
    drive(0, 0, 1, 198, 0, 0, 0, 5, 200, 0);
    drive(0, 1, 0, 0,   1, 0, 4, 5, 200, 0);
    drive(0, 1, 0, 0,   1, 0, 4, 5, 200, 0);
    drive(0, 1, 0, 0,   0, 1, 0, 5, 200, 0);
    // full-range wrap with carry-out and borrow
    drive(0, 0, 1, 254, 0, 0, 0, 0, 255, 1);
    drive(0, 1, 0, 0,   1, 0, 3, 0, 255, 1);
    drive(0, 1, 0, 0,   0, 1, 1, 0, 255, 1);
    // Min>Max freezes the counter; reset mid-count
    drive(0, 1, 1, 10,  0, 0, 0, 50, 40, 0);
    drive(0, 1, 0, 0,   1, 0, 5, 50, 40, 0);
    drive(0, 1, 0, 0,   1, 0, 5, 10, 40, 0);
    drive(1, 1, 0, 0,   1, 0, 5, 10, 40, 0);
    drive(0, 0, 0, 0,   0, 0, 0, 10, 40, 0);
    // Min==Max single-value range
    drive(0, 1, 0, 0,   1, 0, 2, 40, 40, 0);
    drive(0, 1, 0, 0,   0, 1, 2, 40, 40, 1);

    // randomized traffic with occasional run-time bound changes
    mn = 20;
    mx = 220;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mn = $urandom_range(0, VMAX);
        mx = $urandom_range(0, VMAX);
        if (mn > mx && $urandom_range(0, 3) != 0) begin
          int t;
          t  = mn;
          mn = mx;
          mx = t;
        end
      end
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, VMAX),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, (1 << STEP_W) - 1),
            mn, mx,
            $urandom_range(0, 1) == 1);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
